// File: rtl/mac_pkg.sv
// Shared constants and FSM state encoding for the 4x4 multiply-accumulate block.
package mac_pkg;

   localparam int OPND_W = 4;
   localparam int PROD_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/mac_4x4_accum_if.sv
// Operand/result bus of mac_4x4_accum. Both sides use valid/ready: a transfer
// happens on the rising edge where valid and ready are both high; valid, once raised, holds its payload until that edge.
interface mac_4x4_accum_if #(
   parameter int ACC_W = 16
);
   import mac_pkg::*;

   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [OPND_W-1:0] a;
   logic [OPND_W-1:0] b;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              overflow;

   modport master (
      output clear, in_valid, a, b, in_last, out_ready,
      input  in_ready, out_valid, acc_out, overflow
   );

   modport slave (
      input  clear, in_valid, a, b, in_last, out_ready,
      output in_ready, out_valid, acc_out, overflow
   );

endinterface

// File: rtl/mac_4x4_accum_mul4.sv
// mul4_array: combinational unsigned 4x4 multiplier built from shifted partial products.
module mul4_array
   import mac_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic [PROD_W-1:0] prod
);

   always_comb begin
      prod = '0;
      for (int i = 0; i < OPND_W; i++) begin
         if (b[i]) prod = prod + (PROD_W'(a) << i);
      end
   end

endmodule

// File: rtl/mac_4x4_accum.sv
// Packet multiply-accumulate: S1 registers a*b, S2 sums it; result held until taken.
// Define MAC_SATURATE_EN to saturate the accumulator instead of wrapping.
module mac_4x4_accum
   import mac_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   mac_4x4_accum_if.slave bus,
   output state_t         dbg_state
);

   localparam int SUM_W = ACC_W + 1;

   state_t             state;
   logic               p_vld;
   logic               p_last;
   logic [PROD_W-1:0]  prod;
   logic [PROD_W-1:0]  prod_q;
   logic [ACC_W-1:0]   acc;
   logic               ovf;
   logic               out_valid;
   logic               accept;
   logic [SUM_W-1:0]   sum;
   logic [ACC_W-1:0]   acc_next;

   mul4_array u_mul (
      .a    (bus.a),
      .b    (bus.b),
      .prod (prod)
   );

   // A last beat waiting in S1 blocks further beats so packets never interleave.
   assign bus.in_ready = (state != HOLD) && !(p_vld && p_last);
   assign accept       = bus.in_valid && bus.in_ready && !bus.clear;

   assign sum = {1'b0, acc} + SUM_W'(prod_q);

`ifdef MAC_SATURATE_EN
   assign acc_next = (sum[ACC_W] || ovf) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_next = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         state     <= IDLE;
         p_vld     <= 1'b0;
         p_last    <= 1'b0;
         prod_q    <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         p_vld <= accept;
         if (accept) begin
            prod_q <= prod;
            p_last <= bus.in_last;
         end
         case (state)
            IDLE: begin
               if (p_vld) begin
                  acc   <= ACC_W'(prod_q);
                  ovf   <= 1'b0;
                  state <= p_last ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (p_vld) begin
                  acc <= acc_next;
                  if (sum[ACC_W]) ovf <= 1'b1;
                  if (p_last) state <= HOLD;
               end
            end
            HOLD: begin
               // out_valid rises one edge after entering HOLD, then waits for the consumer.
               if (out_valid && bus.out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.acc_out   = acc;
   assign bus.overflow  = ovf;
   assign dbg_state     = state;

endmodule

// File: tb/tb_mac_4x4_accum.sv
// Self-checking bench for mac_4x4_accum (ACC_W=8); expected results come from whole-packet arithmetic.
module tb_mac_4x4_accum;
   import mac_pkg::*;

   localparam int ACC_W    = 8;
   localparam int MAX_WAIT = 64;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t dbg_state;
   int     cyc = 0;
   int     total = 0;
   int     bad = 0;
   logic [ACC_W:0] exp_q[$];

   mac_4x4_accum_if #(.ACC_W(ACC_W)) bus ();

   mac_4x4_accum #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected {overflow, acc_out} for a packet whose true product sum is psum.
   function automatic logic [ACC_W:0] model_packet(input int psum);
      logic [ACC_W:0] r;
      int lim;
      lim = (1 << ACC_W) - 1;
      r[ACC_W] = (psum > lim);
`ifdef MAC_SATURATE_EN
      r[ACC_W-1:0] = (psum > lim) ? ACC_W'(lim) : ACC_W'(psum);
`else
      r[ACC_W-1:0] = ACC_W'(psum % (1 << ACC_W));
`endif
      return r;
   endfunction

   task automatic send_beat(input logic [3:0] av, input logic [3:0] bv, input logic last,
                            output int acc_cyc);
      int n;
      n = 0;
      bus.a = av; bus.b = bv; bus.in_last = last; bus.in_valid = 1'b1;
      while (!bus.in_ready && n < MAX_WAIT) begin tick; n++; end
      if (!bus.in_ready) begin
         total++; bad++;
         $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
      end
      tick;
      acc_cyc = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic get_result(input int hold_cycles, output logic [ACC_W-1:0] acc,
                             output logic ovf, output int seen_cyc);
      int n;
      n = 0;
      while (!bus.out_valid && n < MAX_WAIT) begin tick; n++; end
      if (!bus.out_valid) begin
         total++; bad++;
         $display("FAIL result_timeout out_valid=%0b required=1", bus.out_valid);
      end
      seen_cyc = cyc;
      acc = bus.acc_out;
      ovf = bus.overflow;
      repeat (hold_cycles) tick;
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
      repeat (3) tick;
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      rst_n = 1'b1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
      total++; if (bus.acc_out !== '0) begin bad++; $display("FAIL reset_acc got=%0d want=0", bus.acc_out); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", bus.overflow); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
      tick;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_after got=%0b want=1", bus.in_ready); end
   endtask

   task automatic test_basic;
      int ac, sc, dummy;
      logic [ACC_W-1:0] acc;
      logic ovf;
      send_beat(4'd3, 4'd5, 1'b0, dummy);
      send_beat(4'd15, 4'd15, 1'b1, ac);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_throttle in_ready=%0b want=0", bus.in_ready); end
      get_result(0, acc, ovf, sc);
      total++; if (sc - ac != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", sc - ac); end
      total++; if (acc !== 8'd240) begin bad++; $display("FAIL basic_acc got=%0d want=240", acc); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%0b want=0", ovf); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0b want=0", bus.out_valid); end
   endtask

   task automatic test_overflow;
      int sc, dummy;
      logic [ACC_W-1:0] acc;
      logic ovf;
      logic [ACC_W:0] e;
      e = model_packet(450);
      send_beat(4'd15, 4'd15, 1'b0, dummy);
      send_beat(4'd15, 4'd15, 1'b1, dummy);
      get_result(1, acc, ovf, sc);
`ifdef MAC_SATURATE_EN
      total++; if (acc !== 8'd255) begin bad++; $display("FAIL ovf_acc got=%0d want=255", acc); end
`else
      total++; if (acc !== 8'd194) begin bad++; $display("FAIL ovf_acc got=%0d want=194", acc); end
`endif
      total++; if ({ovf, acc} !== e) begin bad++; $display("FAIL ovf_model got=%0h want=%0h", {ovf, acc}, e); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", ovf); end
   endtask

   task automatic test_hold;
      int n, sc, dummy;
      logic [ACC_W-1:0] acc;
      logic ovf;
      logic [ACC_W:0] e;
      e = model_packet(675);
      send_beat(4'd15, 4'd15, 1'b0, dummy);
      send_beat(4'd15, 4'd15, 1'b0, dummy);
      send_beat(4'd15, 4'd15, 1'b1, dummy);
      n = 0;
      while (!bus.out_valid && n < MAX_WAIT) begin tick; n++; end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_last = 1'($urandom_range(0, 1));
         bus.a = 4'($urandom_range(0, 15));
         bus.b = 4'($urandom_range(0, 15));
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got=%0b want=0", i, bus.in_ready); end
         tick;
         total++; if ({bus.out_valid, bus.overflow, bus.acc_out} !== {1'b1, e}) begin
            bad++; $display("FAIL hold_stable[%0d] got=%0b/%0h want=1/%0h", i, bus.out_valid, {bus.overflow, bus.acc_out}, e);
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%0b want=0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_reopen got=%0b want=1", bus.in_ready); end
      send_beat(4'd2, 4'd2, 1'b1, dummy);
      get_result(0, acc, ovf, sc);
      total++; if ({ovf, acc} !== {1'b0, 8'd4}) begin bad++; $display("FAIL hold_next got=%0b/%0d want=0/4", ovf, acc); end
   endtask

   task automatic test_clear;
      int sc, dummy;
      logic seen;
      logic [ACC_W-1:0] acc;
      logic ovf;
      send_beat(4'd15, 4'd15, 1'b0, dummy);
      send_beat(4'd15, 4'd15, 1'b0, dummy);
      bus.clear = 1'b1;
      bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
      tick;
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      total++; if ({bus.out_valid, bus.overflow, bus.acc_out} !== '0) begin
         bad++; $display("FAIL clear_outputs got=%0b/%0b/%0d want=0/0/0", bus.out_valid, bus.overflow, bus.acc_out);
      end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL clear_in_ready got=%0b want=1", bus.in_ready); end
      total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL clear_state got=%0d want=%0d", dbg_state, IDLE); end
      seen = 1'b0;
      repeat (6) begin tick; if (bus.out_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL clear_no_result got=%0b want=0", seen); end
      send_beat(4'd1, 4'd7, 1'b1, dummy);
      get_result(0, acc, ovf, sc);
      total++; if ({ovf, acc} !== {1'b0, 8'd7}) begin bad++; $display("FAIL clear_next got=%0b/%0d want=0/7", ovf, acc); end
   endtask

   task automatic test_reset_mid;
      int dummy;
      logic seen;
      send_beat(4'd5, 4'd5, 1'b0, dummy);
      send_beat(4'd3, 4'd3, 1'b1, dummy);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      total++; if ({bus.out_valid, bus.overflow, bus.acc_out} !== '0) begin
         bad++; $display("FAIL rstmid_outputs got=%0b/%0b/%0d want=0/0/0", bus.out_valid, bus.overflow, bus.acc_out);
      end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%0b want=1", bus.in_ready); end
      seen = 1'b0;
      repeat (6) begin tick; if (bus.out_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_result got=%0b want=0", seen); end
   endtask

   task automatic test_back_to_back;
      int sent, got, n;
      logic accepted;
      logic [ACC_W:0] e;
      localparam int NPKT = 20;
      sent = 0; got = 0; n = 0;
      bus.out_ready = 1'b1;
      bus.in_last = 1'b1; bus.in_valid = 1'b1;
      bus.a = 4'($urandom_range(0, 15)); bus.b = 4'($urandom_range(0, 15));
      while ((sent < NPKT || exp_q.size() > 0) && n < 2000) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++; $display("FAIL b2b_spurious got=%0d want=none", bus.acc_out);
            end else begin
               e = exp_q.pop_front();
               total++; if ({bus.overflow, bus.acc_out} !== e) begin
                  bad++; $display("FAIL b2b_result[%0d] got=%0h want=%0h", got, {bus.overflow, bus.acc_out}, e);
               end
            end
            got++;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold_ready got=%0b want=0", bus.in_ready); end
         end
         accepted = bus.in_valid && bus.in_ready;
         if (accepted) begin
            exp_q.push_back(model_packet(int'(bus.a) * int'(bus.b)));
            sent++;
         end
         tick; n++;
         if (accepted) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_throttle got=%0b want=0", bus.in_ready); end
            if (sent < NPKT) begin
               bus.a = 4'($urandom_range(0, 15)); bus.b = 4'($urandom_range(0, 15));
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_last = 1'b0;
      total++; if (got != NPKT || exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_count got=%0d want=%0d pending=%0d", got, NPKT, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_random;
      int nb, psum, sc, dummy;
      logic [3:0] av, bv;
      logic [ACC_W-1:0] acc;
      logic ovf;
      logic [ACC_W:0] e;
      for (int p = 0; p < 15; p++) begin
         nb = $urandom_range(1, 6);
         psum = 0;
         for (int i = 0; i < nb; i++) begin
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15));
            psum += int'(av) * int'(bv);
            repeat ($urandom_range(0, 2)) tick;
            send_beat(av, bv, (i == nb - 1), dummy);
         end
         e = model_packet(psum);
         get_result($urandom_range(0, 3), acc, ovf, sc);
         total++; if ({ovf, acc} !== e) begin
            bad++; $display("FAIL rand_pkt[%0d] got=%0b/%0d want=%0b/%0d", p, ovf, acc, e[ACC_W], e[ACC_W-1:0]);
         end
      end
   endtask

   initial begin
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
      test_reset;
      test_basic;
      test_overflow;
      test_hold;
      test_clear;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mac_4x4_accum.md
MAC_4X4_ACCUM -- requirements
Module: mac_4x4_accum

Interface
REQ-001 SHALL have parameter: ACC_W, 16, accumulator/result width; legal range 8..32.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port: clear  in  1  synchronous flush of the current packet.
REQ-005 SHALL have port: in_valid  in  1  operand beat valid.
REQ-006 SHALL have port: in_ready  out  1  operand beat accepted when in_valid && in_ready at the clock edge.
REQ-007 SHALL have ports: a  in  4  and  b  in  4  unsigned operands.
REQ-008 SHALL have port: in_last  in  1  marks the final beat of a packet.
REQ-009 SHALL have port: out_valid  out  1  accumulated result valid.
REQ-010 SHALL have port: out_ready  in  1  consumer accepts the result when out_valid && out_ready.
REQ-011 SHALL have port: acc_out  out  ACC_W  packet sum of a*b.
REQ-012 SHALL have port: overflow  out  1  sticky per-packet overflow flag, valid with out_valid.

Function
REQ-013 SHALL use a 2-stage pipeline: S1 registers the 8-bit product, p_last and p_vld; S2 adds the product to the accumulator.
REQ-014 SHALL use FSM states IDLE (no beat in the packet), ACCUM (at least one beat summed) and HOLD (result presented).
REQ-015 SHALL drive in_ready = (state != HOLD) && !(p_vld && p_last); beats are never dropped or duplicated.
REQ-016 SHALL, when S2 consumes a beat in IDLE, load acc with the zero-extended product and clear overflow; in ACCUM it SHALL add the product to acc.
REQ-017 SHALL transition IDLE->ACCUM on consuming a non-last beat, IDLE/ACCUM->HOLD on consuming a p_last beat, and HOLD->IDLE on out_valid && out_ready.
REQ-018 SHALL assert out_valid on the second rising edge after the edge that accepted the in_last beat; a single-beat packet SHALL produce a*b.
REQ-019 SHALL hold out_valid, acc_out and overflow stable in HOLD until accepted, regardless of in_valid.
REQ-020 SHALL deassert out_valid on the edge after acceptance, and SHALL accept a new beat no earlier than that edge.
REQ-021 SHALL set overflow when an addition carries out of bit ACC_W-1; once set it SHALL stay set until the next packet starts.
REQ-022 SHALL, on clear, empty S1, return the FSM to IDLE, drop out_valid and zero acc_out and overflow on the next edge. clear SHALL override any simultaneous handshake, and the beat offered in that cycle SHALL NOT be accepted.
REQ-023 SHALL treat in_valid with in_last high while in HOLD as not accepted (in_ready is 0).

Reset
REQ-024 SHALL, while rst_n=0 at the clock edge, force state=IDLE, S1 empty, acc_out=0, overflow=0 and out_valid=0; in_ready SHALL read 1 in the first cycle after release.
REQ-025 SHALL discard any in-flight packet on reset mid-operation, with no partial result emitted.

Configuration
REQ-026 SHALL saturate acc at 2^ACC_W-1 on overflow when MAC_SATURATE_EN is defined; later adds SHALL keep it saturated.
REQ-027 SHALL wrap acc modulo 2^ACC_W when MAC_SATURATE_EN is not defined; overflow SHALL behave identically in both builds.

Structure
REQ-028 SHALL place OPND_W=4, PROD_W=8 and the FSM state enum in shared package mac_pkg.
REQ-029 SHALL instantiate one combinational sub-module, mul4_array, computing the 8-bit unsigned product of the 4-bit a and b; S1 registers its output.

Verification
REQ-030 SHALL cover: beats (3,5),(15,15,last) -> out_valid 2 edges after the last accept, acc_out=240, overflow=0.
REQ-031 SHALL cover: ACC_W=8, beats (15,15),(15,15,last) -> wrap build acc_out=194 with overflow=1; MAC_SATURATE_EN build acc_out=255 with overflow=1.
REQ-032 SHALL cover: out_ready held low 5 cycles in HOLD -> acc_out stable, in_ready=0; accept, then next packet (2,2,last) -> acc_out=4 with overflow=0.
REQ-033 SHALL cover: clear asserted after 2 beats of a 4-beat packet -> no out_valid; a following packet (1,7,last) -> acc_out=7.
REQ-034 SHALL cover: rst_n low for 1 cycle while a last beat sits in S1 -> no out_valid afterwards; all outputs 0 and in_ready=1.
REQ-035 SHALL cover: back-to-back single-beat packets with out_ready tied high -> one result per beat, no beat lost, in_ready throttled per REQ-015.
